// File: rtl/slider_move_driver.sv
`default_nettype none
// ============================================================================
// Module : slider_move_driver
// Checks blank-direction commands against a shadow 2x4 board and drives legal
// moves onto the puzzle as registered (from,to) cell pairs.
// Rev    : 1.0  initial release
// ============================================================================
module slider_move_driver #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_dir,
    output logic             cmd_ready,
    output logic [2:0]       from,
    output logic [2:0]       to,
    output logic             move_valid,
    output logic             move_rejected,
    output logic [2:0]       blank_pos,
    output logic [CNT_W-1:0] move_count,
    output logic             solved
);

    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_board [8];
    logic [2:0]       r_blank;
    logic [2:0]       r_from;
    logic [2:0]       r_to;
    logic             r_move_valid;
    logic             r_rejected;
    logic [CNT_W-1:0] r_count;
    logic             r_solved;

    logic             w_legal;
    logic [2:0]       w_target;
    logic             w_goal;

    // Bit 2 of a cell is its row, bits 1:0 its column.
    always_comb begin
        w_legal  = 1'b0;
        w_target = r_blank;
        case (cmd_dir)
            c_DIR_UP: begin
                w_legal  = r_blank[2];
                w_target = r_blank - 3'd4;
            end
            c_DIR_DOWN: begin
                w_legal  = ~r_blank[2];
                w_target = r_blank + 3'd4;
            end
            c_DIR_LEFT: begin
                w_legal  = (r_blank[1:0] != 2'd0);
                w_target = r_blank - 3'd1;
            end
            c_DIR_RIGHT: begin
                w_legal  = (r_blank[1:0] != 2'd3);
                w_target = r_blank + 3'd1;
            end
            default: begin
                w_legal  = 1'b0;
                w_target = r_blank;
            end
        endcase
    end

    always_comb begin
        w_goal = (r_board[7] == 3'd0);
        for (int i = 0; i < 7; i++) begin
            w_goal = w_goal & (r_board[i] == 3'(i + 1));
        end
    end

    // During ISSUE r_from holds the target cell and r_blank the old blank,
    // so the board swap needs no separate target register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            for (int i = 0; i < 8; i++) begin
                r_board[i] <= 3'(7 - i);
            end
            r_blank      <= 3'd7;
            r_from       <= 3'd7;
            r_to         <= 3'd7;
            r_move_valid <= 1'b0;
            r_rejected   <= 1'b0;
            r_count      <= '0;
            r_solved     <= 1'b0;
        end else begin
            r_rejected <= 1'b0;
            r_solved   <= w_goal;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (w_legal) begin
                            r_state      <= S_ISSUE;
                            r_from       <= w_target;
                            r_to         <= r_blank;
                            r_move_valid <= 1'b1;
                        end else begin
                            r_rejected   <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_board[r_blank] <= r_board[r_from];
                    r_board[r_from]  <= 3'd0;
                    r_blank          <= r_from;
                    r_to             <= r_from;
                    r_move_valid     <= 1'b0;
                    if (r_count != {CNT_W{1'b1}}) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    r_state          <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = (r_state == S_IDLE);
    assign from          = r_from;
    assign to            = r_to;
    assign move_valid    = r_move_valid;
    assign move_rejected = r_rejected;
    assign blank_pos     = r_blank;
    assign move_count    = r_count;
    assign solved        = r_solved;

endmodule
`default_nettype wire
